nios_oci_dct_trace_capture: RTL and testbench

//  Parametrised capture buffer for Nios OCI data-compression-trace (DCT) frames.

---
 rtl/nios_oci_dct_trace_capture.sv | 138 +++++++++++++
 tb/tb_nios_oci_dct_trace_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_oci_dct_trace_capture.sv
// Capture buffer for Nios OCI DCT trace frames: FIFO with registered first-word-fall-through head,
// drop/sequence counters and an end-of-test capture/drain/done sequencer.
module nios_oci_dct_trace_capture #(
   parameter int unsigned DCT_WIDTH   = 30,
   parameter int unsigned COUNT_WIDTH = 4,
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned OVF_WIDTH   = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             capture_enable,
   input  logic                             dct_valid,
   input  logic [DCT_WIDTH-1:0]             dct_buffer,
   input  logic [COUNT_WIDTH-1:0]           dct_count,
   input  logic                             test_ending,
   input  logic                             test_has_ended,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [COUNT_WIDTH+DCT_WIDTH-1:0] out_data,
   output logic [DEPTH_LOG2:0]              fifo_level,
   output logic [OVF_WIDTH-1:0]             overflow_count,
   output logic [15:0]                      frame_seq,
   output logic [1:0]                       state,
   output logic                             done
);

   localparam int unsigned FrameW = COUNT_WIDTH + DCT_WIDTH;
   localparam int unsigned PtrW   = DEPTH_LOG2;
   localparam int unsigned LevelW = DEPTH_LOG2 + 1;
   localparam int unsigned Depth  = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StDrain   = 2'd2,
      StDone    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                ended_q, ended_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LevelW-1:0]   level_q, level_d;
   logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
   logic [15:0]         seq_q, seq_d;
   logic                out_valid_q, out_valid_d;
   logic [FrameW-1:0]   out_data_q, out_data_d;
   logic [FrameW-1:0]   mem_q [Depth];

   logic                wr_req, wr_accept, wr_reject, pop, full;
   logic [LevelW-1:0]   level_after_pop;

   always_comb begin
      wr_req          = dct_valid && (dct_count != '0) && (state_q == StCapture) && !test_ending;
      pop             = out_valid_q && out_ready;
      full            = (level_q == LevelW'(Depth));
      // A full FIFO still accepts when the head leaves on the same edge.
      wr_accept       = wr_req && (!full || pop);
      wr_reject       = wr_req && !wr_accept;
      level_after_pop = level_q - LevelW'(pop);

      level_d  = level_after_pop + LevelW'(wr_accept);
      wr_ptr_d = wr_ptr_q + PtrW'(wr_accept);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      seq_d    = seq_q + 16'(wr_accept);
      ovf_d    = ovf_q;
      if (wr_reject && (ovf_q != '1)) begin
         ovf_d = ovf_q + OVF_WIDTH'(1);
      end

      // Head register only sees frames already in memory, giving one cycle of write latency.
      out_valid_d = (level_after_pop != '0);
      out_data_d  = out_valid_d ? mem_q[rd_ptr_d] : '0;

      ended_d = ended_q | test_has_ended;
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (test_ending) begin
               state_d = StDrain;
            end else if (capture_enable) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            if (test_ending) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if ((ended_q || test_has_ended) && (level_after_pop == '0)) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         ended_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= '0;
         seq_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ended_q     <= ended_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         seq_q       <= seq_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_accept) begin
         mem_q[wr_ptr_q] <= {dct_count, dct_buffer};
      end
   end

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign fifo_level     = level_q;
   assign overflow_count = ovf_q;
   assign frame_seq      = seq_q;
   assign state          = state_q;
   assign done           = (state_q == StDone);

endmodule

// File: tb/tb_nios_oci_dct_trace_capture.sv
// Directed bench for the DCT trace capture buffer; expected frames go into a scoreboard queue
// that a negedge monitor pops on every handshake.
module tb_nios_oci_dct_trace_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        capture_enable = 1'b0;
   logic        dct_valid = 1'b0;
   logic [29:0] dct_buffer = '0;
   logic [3:0]  dct_count = '0;
   logic        test_ending = 1'b0;
   logic        test_has_ended = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [33:0] out_data;
   logic [4:0]  fifo_level;
   logic [7:0]  overflow_count;
   logic [15:0] frame_seq;
   logic [1:0]  state;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] sb[$];

   nios_oci_dct_trace_capture #(
      .DCT_WIDTH  (30),
      .COUNT_WIDTH(4),
      .DEPTH_LOG2 (4),
      .OVF_WIDTH  (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .capture_enable(capture_enable),
      .dct_valid     (dct_valid),
      .dct_buffer    (dct_buffer),
      .dct_count     (dct_count),
      .test_ending   (test_ending),
      .test_has_ended(test_has_ended),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .fifo_level    (fifo_level),
      .overflow_count(overflow_count),
      .frame_seq     (frame_seq),
      .state         (state),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] cnt, input logic [29:0] buff, input bit accept);
      dct_valid  = 1'b1;
      dct_count  = cnt;
      dct_buffer = buff;
      if (accept) sb.push_back({cnt, buff});
      tick();
      dct_valid  = 1'b0;
      dct_count  = '0;
      dct_buffer = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic enable();
      capture_enable = 1'b1;
      tick();
      capture_enable = 1'b0;
   endtask

   // Monitor: negedge sees the same inputs the next rising edge will act on.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 64'(out_data), 64'hDEAD);
            end else begin
               check("pop_data", 64'(out_data), 64'(sb.pop_front()));
            end
         end else if (!out_valid) begin
            check("idle_data_zero", 64'(out_data), 64'h0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      tick();
      tick();
      // Reset state
      check("rst_state", 64'(state), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_ovf", 64'(overflow_count), 64'd0);
      check("rst_seq", 64'(frame_seq), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      tick();
      check("idle_hold", 64'(state), 64'd0);

      // 1: three frames popped in order
      enable();
      check("t1_capture", 64'(state), 64'd1);
      out_ready = 1'b1;
      push(4'h3, 30'h1, 1'b1);
      check("t1_latency_valid", 64'(out_valid), 64'd0);
      check("t1_latency_level", 64'(fifo_level), 64'd1);
      push(4'h1, 30'h2, 1'b1);
      push(4'h2, 30'h3, 1'b1);
      repeat (5) tick();
      check("t1_seq", 64'(frame_seq), 64'd3);
      check("t1_level", 64'(fifo_level), 64'd0);
      check("t1_sb_empty", 64'(sb.size()), 64'd0);
      out_ready = 1'b0;

      // 2: 18 frames into a 16-deep FIFO with no consumer
      do_reset();
      enable();
      for (int i = 0; i < 18; i++) begin
         push(4'((i % 15) + 1), 30'(i + 100), i < 16);
      end
      tick();
      check("t2_level", 64'(fifo_level), 64'd16);
      check("t2_ovf", 64'(overflow_count), 64'd2);
      check("t2_seq", 64'(frame_seq), 64'd16);
      check("t2_valid", 64'(out_valid), 64'd1);

      // 3: full FIFO, push and pop on the same edge
      out_ready = 1'b1;
      push(4'h5, 30'h2AAA, 1'b1);
      out_ready = 1'b0;
      check("t3_level", 64'(fifo_level), 64'd16);
      check("t3_ovf", 64'(overflow_count), 64'd2);
      check("t3_seq", 64'(frame_seq), 64'd17);

      // 4: overflow saturation
      for (int i = 0; i < 252; i++) push(4'h7, 30'(i), 1'b0);
      check("t4_ovf_254", 64'(overflow_count), 64'd254);
      for (int i = 0; i < 48; i++) push(4'h7, 30'(i), 1'b0);
      check("t4_ovf_sat", 64'(overflow_count), 64'hFF);
      check("t4_level", 64'(fifo_level), 64'd16);
      check("t4_seq", 64'(frame_seq), 64'd17);

      // Drain everything, then 5: zero-count frame is ignored
      out_ready = 1'b1;
      repeat (20) tick();
      out_ready = 1'b0;
      check("t5_drained", 64'(fifo_level), 64'd0);
      check("t5_sb_empty", 64'(sb.size()), 64'd0);
      push(4'h0, 30'h3FF, 1'b0);
      tick();
      check("t5_seq", 64'(frame_seq), 64'd17);
      check("t5_level", 64'(fifo_level), 64'd0);
      check("t5_valid", 64'(out_valid), 64'd0);

      // 6: end-of-test sequencing
      do_reset();
      enable();
      for (int i = 0; i < 5; i++) push(4'(i + 1), 30'(i + 500), 1'b1);
      test_ending = 1'b1;
      push(4'h3, 30'h777, 1'b0);
      test_ending = 1'b0;
      check("t6_drain", 64'(state), 64'd2);
      check("t6_level", 64'(fifo_level), 64'd5);
      check("t6_seq", 64'(frame_seq), 64'd5);
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      check("t6_still_drain", 64'(state), 64'd2);
      out_ready = 1'b1;
      repeat (4) tick();
      check("t6_pre_level", 64'(fifo_level), 64'd1);
      check("t6_pre_state", 64'(state), 64'd2);
      check("t6_pre_done", 64'(done), 64'd0);
      tick();
      check("t6_level0", 64'(fifo_level), 64'd0);
      check("t6_done_state", 64'(state), 64'd3);
      check("t6_done", 64'(done), 64'd1);
      out_ready = 1'b0;
      check("t6_sb_empty", 64'(sb.size()), 64'd0);
      capture_enable = 1'b1;
      test_ending = 1'b1;
      tick();
      capture_enable = 1'b0;
      test_ending = 1'b0;
      check("t6_done_sticky", 64'(state), 64'd3);

      // 7: reset while draining with frames queued
      do_reset();
      enable();
      for (int i = 0; i < 7; i++) push(4'h9, 30'(i + 900), 1'b1);
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      check("t7_drain", 64'(state), 64'd2);
      check("t7_level", 64'(fifo_level), 64'd7);
      do_reset();
      check("t7_state", 64'(state), 64'd0);
      check("t7_level0", 64'(fifo_level), 64'd0);
      check("t7_valid", 64'(out_valid), 64'd0);
      check("t7_data", 64'(out_data), 64'd0);
      check("t7_seq", 64'(frame_seq), 64'd0);
      check("t7_ovf", 64'(overflow_count), 64'd0);

      // test_ending beats capture_enable in IDLE; empty drain completes immediately
      capture_enable = 1'b1;
      test_ending = 1'b1;
      tick();
      capture_enable = 1'b0;
      test_ending = 1'b0;
      check("idle_end_wins", 64'(state), 64'd2);
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      check("empty_drain_done", 64'(done), 64'd1);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
